regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, number of registers (range 2..256, power of two not required).
REQ-003 The block SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-005 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to matching reads.
REQ-006 The block SHALL derive localparam AW = max(1, clog2(NREGS)).
REQ-007 The block SHALL have one clock; reset is synchronous and active-high.
REQ-008 Port list:
 clk  in  1  clock, all state updates on rising edge
 reset  in  1  synchronous active-high reset
 ClearReq  in  1  request bulk zeroing of all registers
 ReadReg  in  NRD*AW  packed read addresses, port i at bits [i*AW +: AW]
 ReadData  out  NRD*XLEN  packed read data, port i at bits [i*XLEN +: XLEN]
 WriteReg  in  AW  write address
 WriteData  in  XLEN  write data
 RegWrite  in  1  write enable, sampled on rising clk
 Busy  out  1  clear sequence in progress
 WriteDrop  out  1  a requested write was discarded this cycle

Function
REQ-009 Writes SHALL commit on the rising clk edge when RegWrite=1, Busy=0, and WriteReg < NREGS; written value visible through normal read the following cycle.
REQ-010 Reads SHALL be combinational: ReadData[i] = storage[ReadReg[i]] with zero added latency.
REQ-011 With BYPASS=1, if RegWrite=1, Busy=0, and WriteReg==ReadReg[i] (valid, writable address), ReadData[i] SHALL equal WriteData in the same cycle, for every port independently.
REQ-012 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded without asserting WriteDrop.
REQ-013 Reads of address >= NREGS SHALL return 0; writes to address >= NREGS SHALL be discarded and SHALL assert WriteDrop.
REQ-014 Clear FSM states: IDLE, CLEAR; counter ClrIdx of AW bits.
REQ-015 In CLEAR, each cycle SHALL write 0 to storage[ClrIdx] and increment ClrIdx; on the cycle ClrIdx==NREGS-1 the FSM SHALL transition to IDLE; a full clear takes exactly NREGS cycles.
REQ-016 IDLE with ClearReq=1 SHALL move to CLEAR with ClrIdx=0 on the next edge; ClearReq in CLEAR SHALL be ignored (no restart).
REQ-017 Busy SHALL be 1 exactly while the state is CLEAR.
REQ-018 While Busy=1, all ReadData ports SHALL read 0, and RegWrite=1 SHALL be discarded with WriteDrop=1 in that cycle (combinational).
REQ-019 If RegWrite and ClearReq are both 1 in IDLE, the write SHALL commit and the clear SHALL begin on the next cycle, eventually zeroing it.
REQ-020 WriteDrop SHALL be 0 whenever RegWrite=0.

Reset
REQ-021 While reset=1 at a rising edge, state SHALL become CLEAR with ClrIdx=0; reset wins over ClearReq and RegWrite.
REQ-022 After reset deasserts, Busy SHALL remain 1 for NREGS cycles, leaving every register 0 with no uninitialised storage.
REQ-023 Reset asserted mid-clear SHALL restart the sequence from ClrIdx=0.
REQ-024 Storage array SHALL have no per-entry reset; zeroing is performed only by the clear FSM.

Structure
REQ-025 State encoding (IDLE, CLEAR) and the AW derivation function SHALL live in the shared package regfile_pkg.
REQ-026 Read-port logic (address range check, zero-reg masking, bypass mux, busy gating) SHALL be one sub-module regfile_rdport, instantiated NRD times via generate.

Verification
REQ-027 Reset 1 cycle, then idle -> Busy=1 for exactly 32 cycles, then 0; all 32 registers read 0.
REQ-028 After clear, write reg 5 = 0xDEADBEEF with ReadReg port0=5 -> port0 reads 0xDEADBEEF same cycle (bypass); next cycle, no write, still 0xDEADBEEF.
REQ-029 Write reg 0 = 0x12345678 -> reads of reg 0 return 0, WriteDrop=0.
REQ-030 Issue ClearReq, then RegWrite reg 7 during Busy -> WriteDrop=1, reads return 0; after clear, reg 7 reads 0.
REQ-031 NREGS=24: write addr 30 -> WriteDrop=1; read addr 30 returns 0; clear lasts 24 cycles.
REQ-032 Reset asserted at clear cycle 10 -> Busy then lasts a further full NREGS cycles after deassertion.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: clear-FSM state
// encoding and the address-width helper.
package regfile_pkg;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    // A single-entry or two-entry file still needs a one-bit address.
    function automatic int unsigned addrWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: range check, zero-register masking, write
// bypass and gating while a bulk clear is in progress.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic [AW-1:0]   ReadAddr,
    input  logic [XLEN-1:0] StoreData,
    input  logic [AW-1:0]   WriteReg,
    input  logic [XLEN-1:0] WriteData,
    input  logic            WriteFwd,
    input  logic            Busy,
    output logic [XLEN-1:0] ReadData
);

    logic addrValid;
    logic isZeroReg;
    logic bypassHit;

    always_comb begin
        addrValid = 32'(ReadAddr) < NREGS;
        isZeroReg = (ZERO_REG != 0) && (ReadAddr == '0);
        // WriteFwd already excludes invalid, zero-register and busy writes.
        bypassHit = (BYPASS != 0) && WriteFwd && (WriteReg == ReadAddr);
        ReadData  = '0;
        if (!Busy && addrValid && !isZeroReg) begin
            ReadData = bypassHit ? WriteData : StoreData;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with a sequential bulk-clear
// engine that also initialises storage after reset.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = addrWidth(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ClearReq,
    input  logic [NRD*AW-1:0]   ReadReg,
    output logic [NRD*XLEN-1:0] ReadData,
    input  logic [AW-1:0]       WriteReg,
    input  logic [XLEN-1:0]     WriteData,
    input  logic                RegWrite,
    output logic                Busy,
    output logic                WriteDrop
);

    logic [0:0]      state;
    logic [0:0]      stateNext;
    logic [AW-1:0]   clrIdx;
    logic [AW-1:0]   clrIdxNext;
    logic [XLEN-1:0] storage [NREGS];

    logic wrInRange;
    logic wrZeroReg;
    logic wrForward;
    logic wrCommit;

    assign Busy = (state == StClear);

    always_comb begin
        wrInRange = 32'(WriteReg) < NREGS;
        wrZeroReg = (ZERO_REG != 0) && (WriteReg == '0);
        wrForward = RegWrite && !Busy && wrInRange && !wrZeroReg;
        wrCommit  = wrForward && !reset;
        // Zero-register writes are silently ignored, not reported as drops.
        WriteDrop = RegWrite && (Busy || !wrInRange);
    end

    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        if (state == StClear) begin
            clrIdxNext = clrIdx + 1'b1;
            if (clrIdx == AW'(NREGS - 1)) begin
                stateNext = StIdle;
            end
        end else if (ClearReq) begin
            stateNext  = StClear;
            clrIdxNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StClear;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
        end
    end

    // No per-entry reset: the clear sequence is the only initialisation path.
    always_ff @(posedge clk) begin
        if (Busy) begin
            storage[clrIdx] <= '0;
        end else if (wrCommit) begin
            storage[WriteReg] <= WriteData;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : gRdPort
        logic [AW-1:0]   rdAddr;
        logic [XLEN-1:0] rdRaw;

        assign rdAddr = ReadReg[i*AW +: AW];
        assign rdRaw  = (32'(rdAddr) < NREGS) ? storage[rdAddr] : '0;

        regfile_rdport #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) uRdPort (
            .ReadAddr  (rdAddr),
            .StoreData (rdRaw),
            .WriteReg  (WriteReg),
            .WriteData (WriteData),
            .WriteFwd  (wrForward),
            .Busy      (Busy),
            .ReadData  (ReadData[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 32-entry and a 24-entry instance share stimulus
// and are each compared every cycle against an array-based reference model.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        ClearReq;
    logic        RegWrite;
    logic [9:0]  ReadReg;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [63:0] rdA;
    logic [63:0] rdB;
    logic        busyA;
    logic        busyB;
    logic        dropA;
    logic        dropB;

    int          compared;
    int          mismatched;
    int          nr [2] = '{32, 24};
    int          busyLeft [2];
    int          busyCnt [2];
    logic [31:0] mdl [2][32];

    regfile_param uDutA (
        .clk       (clk),
        .reset     (reset),
        .ClearReq  (ClearReq),
        .ReadReg   (ReadReg),
        .ReadData  (rdA),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Busy      (busyA),
        .WriteDrop (dropA)
    );

    regfile_param #(.NREGS(24)) uDutB (
        .clk       (clk),
        .reset     (reset),
        .ClearReq  (ClearReq),
        .ReadReg   (ReadReg),
        .ReadData  (rdB),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Busy      (busyB),
        .WriteDrop (dropB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int k, input int p);
        return (k == 0) ? rdA[p*32 +: 32] : rdB[p*32 +: 32];
    endfunction

    function automatic logic [31:0] expRead(input int k, input int p);
        int addr;
        addr = int'(ReadReg[p*5 +: 5]);
        if (busyLeft[k] > 0 || addr >= nr[k] || addr == 0) return '0;
        if (RegWrite && int'(WriteReg) == addr) return WriteData;
        return mdl[k][addr];
    endfunction

    function automatic logic expDrop(input int k);
        return RegWrite && (busyLeft[k] > 0 || int'(WriteReg) >= nr[k]);
    endfunction

    task automatic startClear(input int k);
        busyLeft[k] = nr[k];
        for (int a = 0; a < 32; a++) mdl[k][a] = '0;
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later.
    task automatic runCycle;
        #1;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    checkEq($sformatf("rd%0d_p%0d", k, p), rd(k, p), expRead(k, p));
                end
                checkEq($sformatf("busy%0d", k), 32'((k == 0) ? busyA : busyB),
                        32'(busyLeft[k] > 0));
                checkEq($sformatf("drop%0d", k), 32'((k == 0) ? dropA : dropB),
                        32'(expDrop(k)));
            end
        end
        busyCnt[0] += int'(busyA);
        busyCnt[1] += int'(busyB);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                startClear(k);
            end else if (busyLeft[k] > 0) begin
                busyLeft[k]--;
            end else begin
                if (RegWrite && int'(WriteReg) < nr[k] && WriteReg != 0) begin
                    mdl[k][WriteReg] = WriteData;
                end
                if (ClearReq) startClear(k);
            end
        end
        @(negedge clk);
    endtask

    task automatic setIdle;
        reset     = 1'b0;
        ClearReq  = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg   = '0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        busyLeft   = '{0, 0};
        busyCnt    = '{0, 0};
        setIdle();
        // Reset wins over a simultaneous clear request and write.
        reset = 1'b1; ClearReq = 1'b1; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = '1;
        runCycle();
        setIdle();
        busyCnt = '{0, 0};
        repeat (40) runCycle();
        checkEq("rstBusyLenA", 32'(busyCnt[0]), 32'd32);
        checkEq("rstBusyLenB", 32'(busyCnt[1]), 32'd24);

        for (int i = 0; i < 32; i++) begin
            ReadReg = {5'(31 - i), 5'(i)};
            runCycle();
        end

        // Same-cycle bypass, then a plain read of the committed value.
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF; ReadReg = {5'd0, 5'd5};
        #1 checkEq("bypassA", rdA[31:0], 32'hDEADBEEF);
        runCycle();
        RegWrite = 1'b0;
        #1 checkEq("holdA", rdA[31:0], 32'hDEADBEEF);
        runCycle();

        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg = '0;
        #1 checkEq("zeroRegRd", rdA[31:0], 32'h0);
        checkEq("zeroRegDrop", 32'(dropA), 32'd0);
        runCycle();
        RegWrite = 1'b0;
        #1 checkEq("zeroRegAfter", rdA[31:0], 32'h0);
        runCycle();

        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hA5A5A5A5;
        runCycle();
        RegWrite = 1'b0; ClearReq = 1'b1;
        runCycle();
        ClearReq = 1'b0; RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h0BADF00D;
        ReadReg = {5'd7, 5'd7};
        #1 checkEq("busyDropA", 32'(dropA), 32'd1);
        checkEq("busyReadA", rdA[31:0], 32'h0);
        runCycle();
        setIdle();
        ReadReg = {5'd7, 5'd7};
        repeat (40) runCycle();
        #1 checkEq("clearedReg7", rdA[31:0], 32'h0);

        RegWrite = 1'b1; WriteReg = 5'd30; WriteData = 32'hCAFE0030; ReadReg = {5'd30, 5'd30};
        #1 checkEq("oorDropB", 32'(dropB), 32'd1);
        checkEq("inRangeDropA", 32'(dropA), 32'd0);
        runCycle();
        RegWrite = 1'b0;
        #1 checkEq("oorReadB", rdB[31:0], 32'h0);
        checkEq("reg30A", rdA[31:0], 32'hCAFE0030);
        runCycle();
        ClearReq = 1'b1;
        runCycle();
        setIdle();
        busyCnt = '{0, 0};
        repeat (40) runCycle();
        checkEq("clrLenA", 32'(busyCnt[0]), 32'd32);
        checkEq("clrLenB", 32'(busyCnt[1]), 32'd24);

        // Reset ten cycles into a clear restarts the full sequence.
        ClearReq = 1'b1;
        runCycle();
        ClearReq = 1'b0;
        repeat (10) runCycle();
        reset = 1'b1;
        runCycle();
        reset = 1'b0;
        busyCnt = '{0, 0};
        repeat (40) runCycle();
        checkEq("midRstLenA", 32'(busyCnt[0]), 32'd32);
        checkEq("midRstLenB", 32'(busyCnt[1]), 32'd24);

        repeat (3000) begin
            reset     = ($urandom_range(0, 299) == 0);
            ClearReq  = ($urandom_range(0, 79) == 0);
            RegWrite  = $urandom_range(0, 1) == 1;
            WriteReg  = 5'($urandom);
            WriteData = $urandom;
            ReadReg   = 10'($urandom);
            if ($urandom_range(0, 3) == 0) ReadReg[4:0] = WriteReg;
            if ($urandom_range(0, 3) == 0) ReadReg[9:5] = WriteReg;
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
